// File: rtl/snake_input_ctrl.sv
// Button conditioning (sync, debounce, press detect) and snake heading / run-pause control.
// One turn is allowed per snake move; a single extra turn is buffered until the next move_tick.
module snake_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [2:0] btn_raw,
    input  logic       move_tick,
    output logic [2:0] btn_clean,
    output logic [1:0] dir,
    output logic       turn_pulse,
    output logic       run,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       s1, s2, clean_d, press;
    logic [CNT_W-1:0] cnt [3];

    state_t state, state_nx;
    logic [1:0] dir_nx;
    logic       turn_pulse_nx, lock, lock_nx, pend_valid, pend_valid_nx, pend_r, pend_r_nx;
    logic       press_u, press_l, press_r, turn_req;

    // Synchroniser, per-bit debounce counters and registered rising-edge detect.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            btn_clean <= '0;
            clean_d   <= '0;
            press     <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1      <= btn_raw;
            s2      <= s1;
            clean_d <= btn_clean;
            press   <= btn_clean & ~clean_d;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == btn_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_clean[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_u  = press[0];
    assign press_l  = press[1];
    assign press_r  = press[2];
    assign turn_req = press_l ^ press_r;

    function automatic logic [1:0] turned(input logic [1:0] d, input logic right);
        return right ? d + 2'd1 : d - 2'd1;
    endfunction

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dir        <= 2'b01;
            turn_pulse <= 1'b0;
            lock       <= 1'b0;
            pend_valid <= 1'b0;
            pend_r     <= 1'b0;
        end else begin
            state      <= state_nx;
            dir        <= dir_nx;
            turn_pulse <= turn_pulse_nx;
            lock       <= lock_nx;
            pend_valid <= pend_valid_nx;
            pend_r     <= pend_r_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        dir_nx        = dir;
        turn_pulse_nx = 1'b0;
        lock_nx       = lock;
        pend_valid_nx = pend_valid;
        pend_r_nx     = pend_r;
        case (state)
            IDLE: begin
                if (press_u) begin
                    state_nx = RUN;
                    dir_nx   = 2'b01;
                end
            end
            RUN: begin
                if (press_u) begin
                    state_nx      = PAUSE;
                    lock_nx       = 1'b0;
                    pend_valid_nx = 1'b0;
                end else if (move_tick && pend_valid) begin
                    // Buffered turn lands now; a fresh press takes the freed buffer slot.
                    dir_nx        = turned(dir, pend_r);
                    turn_pulse_nx = 1'b1;
                    lock_nx       = 1'b1;
                    pend_valid_nx = turn_req;
                    pend_r_nx     = press_r;
                end else if (turn_req && (!lock || move_tick)) begin
                    dir_nx        = turned(dir, press_r);
                    turn_pulse_nx = 1'b1;
                    lock_nx       = 1'b1;
                end else if (move_tick) begin
                    lock_nx = 1'b0;
                end else if (turn_req && !pend_valid) begin
                    pend_valid_nx = 1'b1;
                    pend_r_nx     = press_r;
                end
            end
            PAUSE: begin
                if (press_u) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign run       = (state == RUN);
    assign fsm_state = state;

endmodule
